sub_pix_delay_lanes: RTL and testbench

SUB_PIX_DELAY_LANES -- requirements
Module: sub_pix_delay_lanes

---
 rtl/sub_pix_delay_lanes.sv | 151 +++++++++++++++
 tb/tb_sub_pix_delay_lanes.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_pix_delay_lanes.sv
// Fractional sub-pixel shift of a multi-lane pixel stream: each pixel is blended
// toward its next or previous neighbour by fract/2^FW, with edge replication per line.
module sub_pix_delay_lanes #(
    parameter int LANES = 4,
    parameter int DW    = 14,
    parameter int FW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [LANES*DW-1:0]   s_data,
    input  logic                  s_last,
    input  logic [FW-1:0]         fract,
    input  logic                  shift_dir,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LANES*DW-1:0]   m_data,
    output logic                  m_last
);

    // state | meaning
    // EMPTY | no beat held; next accepted beat starts a line
    // HOLD  | one beat held, waiting for the next beat's lane 0 as its right neighbour
    // FLUSH | final beat of the line held; emit it with right-edge replication
    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;

    localparam logic signed [DW+FW+1:0] HALF = $signed((DW+FW+2)'(1) << (FW-1));

    state_t              state_q, state_d;
    logic [LANES*DW-1:0] hold_q, hold_d;
    logic [DW-1:0]       prev_q, prev_d;
    logic [FW-1:0]       fract_q, fract_d;
    logic                dir_q, dir_d;
    logic                m_valid_q, m_valid_d;
    logic [LANES*DW-1:0] m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic                out_free;
    logic                accept;

    // ext holds {next, beat, prev} so lane j sees its neighbours at j and j+2
    function automatic logic [LANES*DW-1:0] interp(
        input logic [LANES*DW-1:0] cur,
        input logic [DW-1:0]       prev,
        input logic [DW-1:0]       next,
        input logic [FW-1:0]       f,
        input logic                dir
    );
        logic [(LANES+2)*DW-1:0] ext;
        logic [DW-1:0]           xc;
        logic [DW-1:0]           nb;
        logic signed [DW:0]      diff;
        logic signed [DW+FW+1:0] fs;
        logic signed [DW+FW+1:0] ds;
        logic signed [DW+FW+1:0] prod;
        logic [DW-1:0]           step;
        logic [LANES*DW-1:0]     y;
        ext = {next, cur, prev};
        y   = '0;
        for (int j = 0; j < LANES; j++) begin
            xc   = ext[(j+1)*DW +: DW];
            nb   = dir ? ext[(j+2)*DW +: DW] : ext[j*DW +: DW];
            diff = $signed({1'b0, nb}) - $signed({1'b0, xc});
            fs   = $signed({{(DW+2){1'b0}}, f});
            ds   = {{(FW+1){diff[DW]}}, diff};
            prod = fs * ds;
            step = DW'((prod + HALF) >>> FW);
            y[j*DW +: DW] = xc + step;
        end
        return y;
    endfunction

    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = (state_q != FLUSH) && out_free;
    assign accept   = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        prev_d    = prev_q;
        fract_d   = fract_q;
        dir_d     = dir_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    hold_d  = s_data;
                    prev_d  = s_data[DW-1:0];
                    fract_d = fract;
                    dir_d   = shift_dir;
                    state_d = s_last ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    m_data_d  = interp(hold_q, prev_q, s_data[DW-1:0], fract_q, dir_q);
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    prev_d    = hold_q[(LANES-1)*DW +: DW];
                    hold_d    = s_data;
                    state_d   = s_last ? FLUSH : HOLD;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    m_data_d  = interp(hold_q, prev_q, hold_q[(LANES-1)*DW +: DW], fract_q, dir_q);
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    state_d   = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= EMPTY;
            hold_q    <= '0;
            prev_q    <= '0;
            fract_q   <= '0;
            dir_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            prev_q    <= prev_d;
            fract_q   <= fract_d;
            dir_q     <= dir_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_sub_pix_delay_lanes.sv
// Bench for sub_pix_delay_lanes: directed and random lines checked against a
// whole-line arithmetic model of the fractional shift with edge replication.
module tb_sub_pix_delay_lanes;

    localparam int LANES = 4;
    localparam int DW    = 14;
    localparam int FW    = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                s_valid;
    logic                s_ready;
    logic [LANES*DW-1:0] s_data;
    logic                s_last;
    logic [FW-1:0]       fract;
    logic                shift_dir;
    logic                m_valid;
    logic                m_ready;
    logic [LANES*DW-1:0] m_data;
    logic                m_last;

    int total = 0;
    int bad   = 0;
    bit acc;
    bit rand_ready = 1'b0;
    logic [LANES*DW-1:0] exp_data[$];
    bit                  exp_last[$];

    sub_pix_delay_lanes #(.LANES(LANES), .DW(DW), .FW(FW)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fract(fract), .shift_dir(shift_dir),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] beat_of(input int px[$], input int b);
        logic [LANES*DW-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++) r[j*DW +: DW] = px[b*LANES+j][DW-1:0];
        return r;
    endfunction

    // Whole-line reference: y[i] = x[i] + floor((f*(x[i+d]-x[i]) + 2^(FW-1)) / 2^FW)
    task automatic push_model(input int px[$], input int f, input bit dir);
        int n;
        int y[$];
        n = px.size();
        for (int i = 0; i < n; i++) begin
            int xi, nbr, sh;
            xi  = px[i];
            nbr = dir ? px[(i == n-1) ? i : i+1] : px[(i == 0) ? 0 : i-1];
            sh  = (f * (nbr - xi) + (1 << (FW-1))) >>> FW;
            y.push_back((xi + sh) & ((1 << DW) - 1));
        end
        for (int b = 0; b < n / LANES; b++) begin
            exp_data.push_back(beat_of(y, b));
            exp_last.push_back(b == n / LANES - 1);
        end
    endtask

    task automatic sample_out();
        if (m_valid && m_ready) begin
            total++;
            assert (exp_data.size() > 0) else begin
                bad++;
                $error("FAIL spurious_out observed=%h expected=no_beat", m_data);
            end
            if (exp_data.size() > 0) begin
                chk("out_data", m_data, exp_data.pop_front());
                chk("out_last", m_last, exp_last.pop_front());
            end
        end
        acc = s_valid && s_ready;
    endtask

    task automatic clk_step();
        @(negedge clk);
        sample_out();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_accept();
        acc = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) clk_step();
        chk("accept_timeout", acc, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && exp_data.size() > 0; k++) clk_step();
        chk("drain_empty", exp_data.size(), 0);
    endtask

    // later_f < 0 scrambles fract/dir on non-first beats; the line must ignore them
    task automatic send_line(input int px[$], input int f, input bit dir,
                             input int later_f, input bit gaps);
        int nb;
        push_model(px, f, dir);
        nb = px.size() / LANES;
        for (int b = 0; b < nb; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) clk_step();
            s_data  = beat_of(px, b);
            s_last  = (b == nb - 1);
            s_valid = 1'b1;
            if (b == 0) begin
                fract     = FW'(f);
                shift_dir = dir;
            end else if (later_f < 0) begin
                fract     = FW'($urandom);
                shift_dir = 1'($urandom);
            end else begin
                fract     = FW'(later_f);
                shift_dir = dir;
            end
            wait_accept();
            s_valid = 1'b0;
        end
    endtask

    initial begin
        int px[$];
        logic [LANES*DW-1:0] saved;
        reset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        fract = '0; shift_dir = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 1);

        // identity, shift toward next, shift toward previous
        px = '{10, 20, 30, 40, 50, 60, 70, 80};
        send_line(px, 0, 1'b1, -1, 1'b0);
        send_line(px, 128, 1'b1, -1, 1'b0);
        send_line(px, 128, 1'b0, -1, 1'b0);
        drain();

        // single-beat line latency: accepted in cycle t, visible in t+2
        px = '{500, 900, 100, 16383};
        push_model(px, 77, 1'b1);
        s_data = beat_of(px, 0); s_last = 1'b1; s_valid = 1'b1; fract = 8'd77; shift_dir = 1'b1;
        wait_accept();
        s_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_valid", m_valid, 0);
        sample_out();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_t2_valid", m_valid, 1);
        sample_out();
        @(posedge clk);
        #1;
        drain();

        // backpressure with output full and a new line offered
        m_ready = 1'b0;
        px = '{1000, 3000, 200, 9000, 16000, 5, 7000, 8000};
        send_line(px, 64, 1'b1, -1, 1'b0);
        px = '{11, 12000, 13, 14000};
        push_model(px, 200, 1'b0);
        s_data = beat_of(px, 0); s_last = 1'b1; s_valid = 1'b1; fract = 8'd200; shift_dir = 1'b0;
        saved = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", m_valid, 1);
            chk("stall_s_ready", s_ready, 0);
            if (k == 0) saved = m_data;
            else chk("stall_data", m_data, saved);
            sample_out();
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        wait_accept();
        s_valid = 1'b0;
        drain();

        // fract changes mid-line are ignored until the next line
        px = '{100, 300, 500, 700, 900, 1100, 1300, 1500, 1700, 1900, 2100, 2300};
        send_line(px, 128, 1'b1, 0, 1'b0);
        px = '{5, 15, 25, 35, 45, 55, 65, 75};
        send_line(px, 0, 1'b1, -1, 1'b0);
        drain();

        // reset while holding a beat: it is discarded and the next beat starts a line
        px = '{100, 200, 300, 400};
        s_data = beat_of(px, 0); s_last = 1'b0; s_valid = 1'b1; fract = 8'd128; shift_dir = 1'b0;
        wait_accept();
        s_valid = 1'b0;
        reset = 1'b0;
        clk_step();
        reset = 1'b1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_last", m_last, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_s_ready", s_ready, 1);
        px = '{1000, 2000, 3000, 4000};
        send_line(px, 128, 1'b0, -1, 1'b0);
        drain();

        // random lines with random backpressure and input gaps
        rand_ready = 1'b1;
        for (int l = 0; l < 30; l++) begin
            int nbeats, f;
            bit dir;
            px.delete();
            nbeats = $urandom_range(1, 5);
            for (int i = 0; i < nbeats * LANES; i++) px.push_back($urandom_range(0, (1 << DW) - 1));
            case ($urandom_range(0, 3))
                0: f = 0;
                1: f = (1 << FW) - 1;
                default: f = $urandom_range(0, (1 << FW) - 1);
            endcase
            dir = 1'($urandom);
            send_line(px, f, dir, -1, 1'b1);
        end
        drain();
        rand_ready = 1'b0;
        m_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
